// File: rtl/mem_loader.sv
// mem_loader: byte-stream program loader for the cpu_mem write port.
// Stream format: count N (2 bytes, high first), N words (high byte first),
// then an optional checksum byte.
// Holds the CPU halted while the image loads and pulses done when finished.
// Optional feature: define MEM_LOADER_CHECKSUM_EN to accept a trailing
// XOR checksum byte and flag a mismatch on err_o.
// WORD_WIDTH must be 16 (two bytes per word).

`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module mem_loader #(
    parameter int unsigned            WORD_WIDTH = `WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_data_i,
    output logic                  in_ready_o,
    output logic [WORD_WIDTH-1:0] mem_addr_o,
    output logic [WORD_WIDTH-1:0] mem_data_o,
    output logic                  mem_write_en_o,
    output logic                  cpu_halt_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StWrite,
`ifdef MEM_LOADER_CHECKSUM_EN
        StCsum,
`endif
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] len_q, len_d;
    logic [WORD_WIDTH-1:0] idx_q, idx_d;
    logic [WORD_WIDTH-1:0] idx_inc;
    logic [7:0]            byte_hi_q, byte_hi_d;
    logic [WORD_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  xfer;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic                  err_q, err_d;
`endif

    // in_ready depends only on state: high in the byte-consuming states
    always_comb begin
        in_ready_o = 1'b0;
        case (state_q)
            StLenHi, StLenLo, StDataHi, StDataLo: in_ready_o = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            StCsum:                               in_ready_o = 1'b1;
`endif
            default:                              in_ready_o = 1'b0;
        endcase
    end

    assign xfer    = in_valid_i && in_ready_o;
    assign idx_inc = idx_q + 1'b1;

    // Next-state logic and per-state outputs
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        byte_hi_d      = byte_hi_q;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        mem_write_en_o = 1'b0;
        done_o         = 1'b0;
        cpu_halt_o     = (state_q != StIdle);
`ifdef MEM_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
        err_d          = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLenHi;
                    idx_d   = '0;
`ifdef MEM_LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
                    err_d   = 1'b0;
`endif
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_d   = {in_data_i, len_q[7:0]};
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d = {len_q[15:8], in_data_i};
                    if ({len_q[15:8], in_data_i} != '0) begin
                        state_d = StDataHi;
                    end else begin
`ifdef MEM_LOADER_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
            StDataHi: begin
                if (xfer) begin
                    byte_hi_d = in_data_i;
`ifdef MEM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ in_data_i;
`endif
                    state_d   = StDataLo;
                end
            end
            StDataLo: begin
                if (xfer) begin
                    mem_data_d = {byte_hi_q, in_data_i};
                    // Wraps modulo 2^WORD_WIDTH by construction
                    mem_addr_d = BASE_ADDR + idx_q;
`ifdef MEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data_i;
`endif
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                mem_write_en_o = 1'b1;
                idx_d          = idx_inc;
                if (idx_inc == len_q) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StDataHi;
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            StCsum: begin
                if (xfer) begin
                    err_d   = (in_data_i != csum_q);
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any load in progress
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            len_q      <= '0;
            idx_q      <= '0;
            byte_hi_q  <= 8'h00;
            mem_addr_q <= BASE_ADDR;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            byte_hi_q  <= byte_hi_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    // Running XOR of data bytes and the sticky mismatch flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= 8'h00;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader.
// Two instances share the stimulus: dut0 with BASE_ADDR 0, dut1 with
// BASE_ADDR 16'hFFFF for the address-wrap case.
// Honours MEM_LOADER_CHECKSUM_EN by appending checksum bytes.

module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        rdy0, we0, halt0, done0, err0;
    logic [15:0] addr0, data0;
    logic        rdy1, we1, halt1, done1, err1;
    logic [15:0] addr1, data1;

    int checks = 0;
    int errors = 0;

    logic [15:0] wa0[$], wd0[$], wa1[$], wd1[$];
    int          done_cnt = 0;
    int          halt_after_done = 0;
    int          halt_in_done_low = 0;
    int          ready_in_write = 0;
    logic        done_prev = 1'b0;
    logic [7:0]  stream[$];

    mem_loader #(.WORD_WIDTH(16), .BASE_ADDR(16'h0000)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(rdy0), .mem_addr_o(addr0), .mem_data_o(data0),
        .mem_write_en_o(we0), .cpu_halt_o(halt0), .done_o(done0), .err_o(err0)
    );

    mem_loader #(.WORD_WIDTH(16), .BASE_ADDR(16'hFFFF)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(rdy1), .mem_addr_o(addr1), .mem_data_o(data1),
        .mem_write_en_o(we1), .cpu_halt_o(halt1), .done_o(done1), .err_o(err1)
    );

    always #5 clk = ~clk;

    // Log writes and watch done / halt / ready relationships mid-cycle
    always @(negedge clk) begin
        if (we0) begin
            wa0.push_back(addr0);
            wd0.push_back(data0);
        end
        if (we1) begin
            wa1.push_back(addr1);
            wd1.push_back(data1);
        end
        if (we0 && rdy0) ready_in_write <= ready_in_write + 1;
        if (done0) done_cnt <= done_cnt + 1;
        if (done0 && !halt0) halt_in_done_low <= halt_in_done_low + 1;
        if (done_prev && halt0) halt_after_done <= halt_after_done + 1;
        done_prev <= done0 && !rst;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte and hold it until it transfers (bounded)
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!rdy0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("ready_timeout", {31'd0, rdy0}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = 8'hEE;
            if (gap) @(negedge clk);
        end
    endtask

    task automatic send_stream(input bit gap);
        foreach (stream[i]) send_byte(stream[i], gap);
    endtask

    task automatic clear_logs();
        wa0.delete();
        wd0.delete();
        wa1.delete();
        wd1.delete();
    endtask

    task automatic basic_stream();
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef MEM_LOADER_CHECKSUM_EN
        stream.push_back(8'h40);
`endif
    endtask

    task automatic check_basic(input string tag);
        check({tag, "_nwrites"}, wa0.size(), 2);
        check({tag, "_addr0"}, {16'd0, wa0[0]}, 32'h0000);
        check({tag, "_data0"}, {16'd0, wd0[0]}, 32'h1234);
        check({tag, "_addr1"}, {16'd0, wa0[1]}, 32'h0001);
        check({tag, "_data1"}, {16'd0, wd0[1]}, 32'hABCD);
    endtask

    int base_done;

    initial begin
        // Reset asserted with no clock edge: outputs must go to reset values at once
        #2 rst = 1'b1;
        #1;
        check("rst_ready", {31'd0, rdy0}, 0);
        check("rst_we", {31'd0, we0}, 0);
        check("rst_halt", {31'd0, halt0}, 0);
        check("rst_done", {31'd0, done0}, 0);
        check("rst_err", {31'd0, err0}, 0);
        check("rst_addr0", {16'd0, addr0}, 32'h0000);
        check("rst_addr1", {16'd0, addr1}, 32'hFFFF);
        check("rst_data", {16'd0, data0}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic load
        clear_logs();
        base_done = done_cnt;
        start_pulse();
        check("basic_halt_high", {31'd0, halt0}, 1);
        basic_stream();
        send_stream(1'b0);
        repeat (4) @(negedge clk);
        check_basic("basic");
        check("basic_done_cnt", done_cnt - base_done, 1);
        check("basic_halt_low", {31'd0, halt0}, 0);
        check("basic_addr_hold", {16'd0, addr0}, 32'h0001);
        check("basic_data_hold", {16'd0, data0}, 32'hABCD);
        check("basic_err", {31'd0, err0}, 0);

        // Backpressure: in_valid drops for a cycle after every byte
        clear_logs();
        base_done = done_cnt;
        start_pulse();
        basic_stream();
        send_stream(1'b1);
        repeat (4) @(negedge clk);
        check_basic("bp");
        check("bp_done_cnt", done_cnt - base_done, 1);

        // Zero count: DONE follows the last byte's transfer edge
        clear_logs();
        base_done = done_cnt;
        start_pulse();
        stream = '{8'h00, 8'h00};
`ifdef MEM_LOADER_CHECKSUM_EN
        stream.push_back(8'h00);
`endif
        send_stream(1'b0);
        check("zero_done_now", {31'd0, done0}, 1);
        repeat (3) @(negedge clk);
        check("zero_nwrites", wa0.size(), 0);
        check("zero_done_cnt", done_cnt - base_done, 1);
        check("zero_halt_low", {31'd0, halt0}, 0);

        // Abort: reset during word 2 of a 3-word load
        clear_logs();
        base_done = done_cnt;
        start_pulse();
        stream = '{8'h00, 8'h03, 8'hAA, 8'hBB};
        send_stream(1'b0);
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_halt", {31'd0, halt0}, 0);
        check("abort_ready", {31'd0, rdy0}, 0);
        check("abort_addr", {16'd0, addr0}, 32'h0000);
        check("abort_data", {16'd0, data0}, 0);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_nwrites", wa0.size(), 1);
        check("abort_word", {16'd0, wd0[0]}, 32'hAABB);
        check("abort_no_done", done_cnt - base_done, 0);
        check("abort_idle_ready", {31'd0, rdy0}, 0);
        clear_logs();
        base_done = done_cnt;
        start_pulse();
        basic_stream();
        send_stream(1'b0);
        repeat (4) @(negedge clk);
        check_basic("reload");
        check("reload_done_cnt", done_cnt - base_done, 1);

        // Wrap on dut1 (BASE_ADDR = FFFF) with a correct checksum byte
        clear_logs();
        start_pulse();
        stream = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
`ifdef MEM_LOADER_CHECKSUM_EN
        stream.push_back(8'h03);
`endif
        send_stream(1'b0);
        repeat (4) @(negedge clk);
        check("wrap_nwrites", wa1.size(), 2);
        check("wrap_addr0", {16'd0, wa1[0]}, 32'hFFFF);
        check("wrap_data0", {16'd0, wd1[0]}, 32'h0001);
        check("wrap_addr1", {16'd0, wa1[1]}, 32'h0000);
        check("wrap_data1", {16'd0, wd1[1]}, 32'h0002);
        check("wrap_err", {31'd0, err1}, 0);

`ifdef MEM_LOADER_CHECKSUM_EN
        // Bad checksum byte sets err, which holds until the next start
        start_pulse();
        stream = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h04};
        send_stream(1'b0);
        repeat (4) @(negedge clk);
        check("csum_bad_err", {31'd0, err1}, 1);
        start_pulse();
        check("csum_err_cleared", {31'd0, err1}, 0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
`else
        check("err_tied_low", {31'd0, err1}, 0);
`endif

        check("halt_during_done", halt_in_done_low, 0);
        check("halt_after_done", halt_after_done, 0);
        check("ready_during_write", ready_in_write, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
